// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX pipeline stage.
//   master : the surrounding pipeline (drives ID fields, producer buses and
//            stall/flush; observes the EX-side outputs)
//   slave  : the id_ex_stage register itself
// Signal groups:
//   control   stall, flush
//   ID side   id_valid, id_reg_write, id_rs1/rs2/rd_addr, id_rd1, id_rd2,
//             id_imm, id_alu_src, id_operation
//   producers mem_reg_write/mem_rd_addr/mem_result (EX/MEM),
//             wb_reg_write/wb_rd_addr/wb_result (MEM/WB)
//   EX side   SrcA, SrcB, Operation, ex_valid, ex_reg_write, ex_rd_addr,
//             ex_store_data, fwd_a_sel, fwd_b_sel
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR_W    = 5
);
   logic                     stall;
   logic                     flush;
   logic                     id_valid;
   logic                     id_reg_write;
   logic [REG_ADDR_W-1:0]    id_rs1_addr;
   logic [REG_ADDR_W-1:0]    id_rs2_addr;
   logic [REG_ADDR_W-1:0]    id_rd_addr;
   logic [DATA_WIDTH-1:0]    id_rd1;
   logic [DATA_WIDTH-1:0]    id_rd2;
   logic [DATA_WIDTH-1:0]    id_imm;
   logic                     id_alu_src;
   logic [OPCODE_LENGTH-1:0] id_operation;
   logic                     mem_reg_write;
   logic [REG_ADDR_W-1:0]    mem_rd_addr;
   logic [DATA_WIDTH-1:0]    mem_result;
   logic                     wb_reg_write;
   logic [REG_ADDR_W-1:0]    wb_rd_addr;
   logic [DATA_WIDTH-1:0]    wb_result;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic                     ex_valid;
   logic                     ex_reg_write;
   logic [REG_ADDR_W-1:0]    ex_rd_addr;
   logic [DATA_WIDTH-1:0]    ex_store_data;
   logic [1:0]               fwd_a_sel;
   logic [1:0]               fwd_b_sel;

   modport master (
      output stall, flush, id_valid, id_reg_write, id_rs1_addr, id_rs2_addr,
             id_rd_addr, id_rd1, id_rd2, id_imm, id_alu_src, id_operation,
             mem_reg_write, mem_rd_addr, mem_result,
             wb_reg_write, wb_rd_addr, wb_result,
      input  SrcA, SrcB, Operation, ex_valid, ex_reg_write, ex_rd_addr,
             ex_store_data, fwd_a_sel, fwd_b_sel
   );

   modport slave (
      input  stall, flush, id_valid, id_reg_write, id_rs1_addr, id_rs2_addr,
             id_rd_addr, id_rd1, id_rd2, id_imm, id_alu_src, id_operation,
             mem_reg_write, mem_rd_addr, mem_result,
             wb_reg_write, wb_rd_addr, wb_result,
      output SrcA, SrcB, Operation, ex_valid, ex_reg_write, ex_rd_addr,
             ex_store_data, fwd_a_sel, fwd_b_sel
   );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding from the EX/MEM and MEM/WB
// producers.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears every stage field, beats stall/flush
//   bus    id_ex_stage_if.slave (ID inputs, producer buses, stall/flush, EX outputs)
// Build option:
//   ID_EX_FORWARD_EN defined   : forwarding muxes plus operand refresh on stall.
//   ID_EX_FORWARD_EN undefined : selects tied to 00, operands are the
//                                registered rd1/rd2, stall is a pure hold and
//                                the producer buses are ignored.
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR_W    = 5
) (
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   logic                     r_vld_p1;
   logic                     r_reg_write_p1;
   logic [REG_ADDR_W-1:0]    r_rs1_addr_p1;
   logic [REG_ADDR_W-1:0]    r_rs2_addr_p1;
   logic [REG_ADDR_W-1:0]    r_rd_addr_p1;
   logic [DATA_WIDTH-1:0]    r_rd1_p1;
   logic [DATA_WIDTH-1:0]    r_rd2_p1;
   logic [DATA_WIDTH-1:0]    r_imm_p1;
   logic                     r_alu_src_p1;
   logic [OPCODE_LENGTH-1:0] r_op_p1;

   logic [1:0]               w_fwd_a_sel;
   logic [1:0]               w_fwd_b_sel;
   logic [DATA_WIDTH-1:0]    w_fwd_a;
   logic [DATA_WIDTH-1:0]    w_fwd_b;

`ifdef ID_EX_FORWARD_EN
   // MEM is the younger producer, so it is checked first. x0 and bubbles
   // never forward.
   function automatic logic [1:0] fwd_sel(
      input logic                  vld,
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  mem_we,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic                  wb_we,
      input logic [REG_ADDR_W-1:0] wb_rd
   );
      if (!vld || rs == '0)          return 2'b00;
      if (mem_we && mem_rd == rs)    return 2'b10;
      if (wb_we && wb_rd == rs)      return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fwd_val(
      input logic [1:0]            sel,
      input logic [DATA_WIDTH-1:0] reg_val,
      input logic [DATA_WIDTH-1:0] mem_val,
      input logic [DATA_WIDTH-1:0] wb_val
   );
      case (sel)
         2'b10:   return mem_val;
         2'b01:   return wb_val;
         default: return reg_val;
      endcase
   endfunction

   always_comb begin
      w_fwd_a_sel = fwd_sel(r_vld_p1, r_rs1_addr_p1, bus.mem_reg_write,
                            bus.mem_rd_addr, bus.wb_reg_write, bus.wb_rd_addr);
      w_fwd_b_sel = fwd_sel(r_vld_p1, r_rs2_addr_p1, bus.mem_reg_write,
                            bus.mem_rd_addr, bus.wb_reg_write, bus.wb_rd_addr);
      w_fwd_a     = fwd_val(w_fwd_a_sel, r_rd1_p1, bus.mem_result, bus.wb_result);
      w_fwd_b     = fwd_val(w_fwd_b_sel, r_rd2_p1, bus.mem_result, bus.wb_result);
   end
`else
   always_comb begin
      w_fwd_a_sel = 2'b00;
      w_fwd_b_sel = 2'b00;
      w_fwd_a     = r_rd1_p1;
      w_fwd_b     = r_rd2_p1;
   end

   logic w_unused_producers;
   assign w_unused_producers = ^{bus.mem_reg_write, bus.mem_rd_addr, bus.mem_result,
                                 bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result};
`endif

   // ---- ID -> EX boundary (p1) ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld_p1       <= 1'b0;
         r_reg_write_p1 <= 1'b0;
         r_rs1_addr_p1  <= '0;
         r_rs2_addr_p1  <= '0;
         r_rd_addr_p1   <= '0;
         r_rd1_p1       <= '0;
         r_rd2_p1       <= '0;
         r_imm_p1       <= '0;
         r_alu_src_p1   <= 1'b0;
         r_op_p1        <= '0;
      end else if (bus.flush) begin
         // Bubble: only the fields that can cause side effects are cleared.
         r_vld_p1       <= 1'b0;
         r_reg_write_p1 <= 1'b0;
         r_op_p1        <= '0;
         r_rd_addr_p1   <= '0;
      end else if (bus.stall) begin
`ifdef ID_EX_FORWARD_EN
         // A producer may retire while we are held; latch its value now so
         // the operand survives once that producer leaves the pipe.
         if (w_fwd_a_sel != 2'b00) r_rd1_p1 <= w_fwd_a;
         if (w_fwd_b_sel != 2'b00) r_rd2_p1 <= w_fwd_b;
`endif
      end else begin
         r_vld_p1       <= bus.id_valid;
         r_reg_write_p1 <= bus.id_valid & bus.id_reg_write;
         r_op_p1        <= bus.id_valid ? bus.id_operation : '0;
         r_rd_addr_p1   <= bus.id_valid ? bus.id_rd_addr : '0;
         r_rs1_addr_p1  <= bus.id_rs1_addr;
         r_rs2_addr_p1  <= bus.id_rs2_addr;
         r_rd1_p1       <= bus.id_rd1;
         r_rd2_p1       <= bus.id_rd2;
         r_imm_p1       <= bus.id_imm;
         r_alu_src_p1   <= bus.id_alu_src;
      end
   end

   assign bus.SrcA          = w_fwd_a;
   assign bus.ex_store_data = w_fwd_b;
   assign bus.SrcB          = r_alu_src_p1 ? r_imm_p1 : w_fwd_b;
   assign bus.Operation     = r_op_p1;
   assign bus.ex_rd_addr    = r_rd_addr_p1;
   assign bus.ex_valid      = r_vld_p1;
   assign bus.ex_reg_write  = r_reg_write_p1 & r_vld_p1;
   assign bus.fwd_a_sel     = w_fwd_a_sel;
   assign bus.fwd_b_sel     = w_fwd_b_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of what the EX stage should present.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int OW = 4;
   localparam int AW = 5;

   logic clk;
   logic reset;

   id_ex_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_W(AW)) bus ();

   id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // What the EX stage currently holds, as an instruction record.
   typedef struct packed {
      bit        vld;
      bit        we;
      bit [3:0]  op;
      bit [4:0]  rd;
      bit [4:0]  rs1;
      bit [4:0]  rs2;
      bit [31:0] rd1;
      bit [31:0] rd2;
      bit [31:0] imm;
      bit        src;
      bit        known;   // data fields defined (not after a bubble)
   } ex_t;

   ex_t m;
   bit  m_init = 1'b0;

   // Which producer an operand should take, from the hazard rules.
   function automatic bit [1:0] exp_sel(ex_t e, bit [4:0] rs);
      if (!e.vld || rs == 5'd0) return 2'd0;
`ifdef ID_EX_FORWARD_EN
      if (bus.mem_reg_write && bus.mem_rd_addr == rs) return 2'd2;
      if (bus.wb_reg_write && bus.wb_rd_addr == rs)   return 2'd1;
`endif
      return 2'd0;
   endfunction

   function automatic bit [31:0] exp_opnd(bit [1:0] sel, bit [31:0] regv);
      if (sel == 2'd2) return bus.mem_result;
      if (sel == 2'd1) return bus.wb_result;
      return regv;
   endfunction

   task automatic check_model();
      bit [1:0]  sa, sb;
      bit [31:0] a, b;
      if (!m_init) return;
      sa = exp_sel(m, m.rs1);
      sb = exp_sel(m, m.rs2);
      a  = exp_opnd(sa, m.rd1);
      b  = exp_opnd(sb, m.rd2);
      chk("ex_valid",     32'(bus.ex_valid),     32'(m.vld));
      chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.we & m.vld));
      chk("Operation",    32'(bus.Operation),    32'(m.op));
      chk("ex_rd_addr",   32'(bus.ex_rd_addr),   32'(m.rd));
      chk("fwd_a_sel",    32'(bus.fwd_a_sel),    32'(sa));
      chk("fwd_b_sel",    32'(bus.fwd_b_sel),    32'(sb));
      if (m.known) begin
         chk("SrcA",          bus.SrcA,          a);
         chk("ex_store_data", bus.ex_store_data, b);
         chk("SrcB",          bus.SrcB,          m.src ? m.imm : b);
      end
   endtask

   task automatic model_next(output ex_t n);
      bit [1:0] sa, sb;
      n = m;
      if (!reset) begin
         n = '0;
         n.known = 1'b1;
      end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
         n.vld = 1'b0; n.we = 1'b0; n.op = 4'd0; n.rd = 5'd0; n.known = 1'b0;
      end else if (bus.stall) begin
         sa = exp_sel(m, m.rs1);
         sb = exp_sel(m, m.rs2);
         if (sa != 2'd0) n.rd1 = exp_opnd(sa, m.rd1);
         if (sb != 2'd0) n.rd2 = exp_opnd(sb, m.rd2);
      end else begin
         n.vld = 1'b1;             n.we  = bus.id_reg_write;
         n.op  = bus.id_operation; n.rd  = bus.id_rd_addr;
         n.rs1 = bus.id_rs1_addr;  n.rs2 = bus.id_rs2_addr;
         n.rd1 = bus.id_rd1;       n.rd2 = bus.id_rd2;
         n.imm = bus.id_imm;       n.src = bus.id_alu_src;
         n.known = 1'b1;
      end
   endtask

   // Inputs are already driven; check current outputs, then take one edge.
   task automatic cyc();
      ex_t n;
      #1;
      check_model();
      model_next(n);
      @(posedge clk);
      m      = n;
      m_init = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit [31:0] rd1, input bit [31:0] rd2,
                         input bit [31:0] imm, input bit src, input bit [3:0] op,
                         input bit we);
      bus.id_valid = v;      bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
      bus.id_rd_addr = rd;   bus.id_rd1 = rd1;      bus.id_rd2 = rd2;
      bus.id_imm = imm;      bus.id_alu_src = src;  bus.id_operation = op;
      bus.id_reg_write = we;
   endtask

   task automatic set_prod(input bit mw, input bit [4:0] mrd, input bit [31:0] mres,
                           input bit ww, input bit [4:0] wrd, input bit [31:0] wres);
      bus.mem_reg_write = mw; bus.mem_rd_addr = mrd; bus.mem_result = mres;
      bus.wb_reg_write  = ww; bus.wb_rd_addr  = wrd; bus.wb_result  = wres;
   endtask

   initial begin
      reset = 1'b0;
      bus.stall = 1'b1;
      bus.flush = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h42, 1'b0, 4'd2, 1'b1);
      set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset held low for two edges while a valid stalled instruction waits.
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         chk("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
         chk("rst_SrcA",      bus.SrcA,           32'd0);
         chk("rst_Operation", 32'(bus.Operation), 32'd0);
      end

      // MEM and WB both target rs1=5: MEM must win.
      reset = 1'b1; bus.stall = 1'b0;
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h10, 32'h20, 32'h30, 1'b0, 4'd2, 1'b1);
      set_prod(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
      cyc();
      #1;
`ifdef ID_EX_FORWARD_EN
      chk("mem_over_wb_sel",  32'(bus.fwd_a_sel), 32'd2);
      chk("mem_over_wb_SrcA", bus.SrcA,           32'hAA);
`else
      chk("nofwd_sel",  32'(bus.fwd_a_sel), 32'd0);
      chk("nofwd_SrcA", bus.SrcA,           32'h10);
`endif

      // rs2 = x0 is never forwarded even when MEM writes x0.
      set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'h11, 32'h0000_5A5A, 32'h99, 1'b0, 4'd1, 1'b1);
      set_prod(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
      cyc();
      #1;
      chk("x0_sel",  32'(bus.fwd_b_sel), 32'd0);
      chk("x0_SrcB", bus.SrcB,           32'h0000_5A5A);

      // Stall refresh: WB retires x3 during a stall and must be remembered.
      set_id(1'b1, 5'd3, 5'd8, 5'd9, 32'h1, 32'h2, 32'h3, 1'b0, 4'd2, 1'b1);
      set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      cyc();
      bus.stall = 1'b1;
      set_prod(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55);
      cyc();
      set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
`ifdef ID_EX_FORWARD_EN
      chk("stall_keep_SrcA", bus.SrcA, 32'h55);
`else
      chk("stall_keep_SrcA", bus.SrcA, 32'h1);
`endif
      cyc();
      #1;
`ifdef ID_EX_FORWARD_EN
      chk("stall_keep2_SrcA", bus.SrcA, 32'h55);
`else
      chk("stall_keep2_SrcA", bus.SrcA, 32'h1);
`endif
      bus.stall = 1'b0;
      set_id(1'b1, 5'd7, 5'd8, 5'd10, 32'h77, 32'h88, 32'h3, 1'b0, 4'd5, 1'b0);
      cyc();
      #1;
      chk("release_SrcA",      bus.SrcA,           32'h77);
      chk("release_Operation", 32'(bus.Operation), 32'd5);

      // Flush wins over stall on a valid ADD.
      set_id(1'b1, 5'd1, 5'd2, 5'd12, 32'h5, 32'h6, 32'h7, 1'b0, 4'b0010, 1'b1);
      cyc();
      bus.stall = 1'b1; bus.flush = 1'b1;
      cyc();
      #1;
      chk("flush_ex_valid",     32'(bus.ex_valid),     32'd0);
      chk("flush_ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
      chk("flush_Operation",    32'(bus.Operation),    32'd0);

      // Reset during a stall drops the held instruction without a refresh.
      bus.stall = 1'b0; bus.flush = 1'b0;
      set_id(1'b1, 5'd3, 5'd4, 5'd13, 32'h21, 32'h22, 32'h23, 1'b0, 4'd6, 1'b1);
      cyc();
      bus.stall = 1'b1; reset = 1'b0;
      set_prod(1'b1, 5'd3, 32'hCC, 1'b0, 5'd0, 32'd0);
      cyc();
      #1;
      chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_stall_SrcA",  bus.SrcA,          32'd0);
      reset = 1'b1; bus.stall = 1'b0;

      // Randomized traffic; small address range makes hazards common.
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 59) != 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 11) == 0);
         set_id(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         set_prod(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         cyc();
      end
      #1;
      check_model();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
